// File: rtl/midi_event_encoder.sv
// MIDI event encoder: serialises framed MIDI events into a byte stream for a
// simpleuart-style transmit port, with running-status compression and refresh.
module midi_event_encoder #(
  parameter bit RUNNING_STATUS    = 1'b1,
  parameter int RS_REFRESH_EVENTS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       event_valid,
  output logic       event_ready,
  input  logic [7:0] event_command,
  input  logic [7:0] event_param_1,
  input  logic [7:0] event_param_2,
  output logic [7:0] tx_data,
  output logic       tx_we,
  input  logic       tx_wait,
  output logic       busy,
  output logic       event_dropped
);

  typedef enum logic [1:0] {IDLE, SEND_STATUS, SEND_P1, SEND_P2} state_t;

  localparam int CW = (RS_REFRESH_EVENTS > 1) ? $clog2(RS_REFRESH_EVENTS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RS_REFRESH_EVENTS - 1);

  state_t        state, next_state;
  logic [7:0]    cmd_q;
  logic [6:0]    p1_q, p2_q;
  logic [1:0]    nbytes_q;
  logic          rs_valid;
  logic [7:0]    rs_cmd;
  logic [CW-1:0] rs_cnt;
  logic [7:0]    tx_data_next;
  logic [7:0]    cmd_src;
  logic [6:0]    p1_src, p2_src;
  logic [1:0]    nbytes_in;
  logic          accept, accept_ok, is_channel, force_refresh, skip_status;

  // Data bit 7 of each parameter is discarded by definition of MIDI data bytes.
  logic unused_param_msbs;
  assign unused_param_msbs = event_param_1[7] ^ event_param_2[7];

  function automatic logic [1:0] data_count(input logic [7:0] cmd);
    logic [1:0] n;
    n = 2'd0;
    case (cmd[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
      4'hC, 4'hD:                   n = 2'd1;
      4'hF: begin
        if (cmd == 8'hF2)                        n = 2'd2;
        else if (cmd == 8'hF1 || cmd == 8'hF3)   n = 2'd1;
        else                                     n = 2'd0;
      end
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  assign event_ready   = (state == IDLE) && resetn;
  assign busy          = (state != IDLE);
  assign tx_we         = (state != IDLE);
  assign accept        = event_valid && event_ready;
  assign accept_ok     = accept && event_command[7];
  assign is_channel    = event_command[7] && (event_command[7:4] != 4'hF);
  assign force_refresh = (RS_REFRESH_EVENTS != 0) && (rs_cnt == CNT_LAST);
  assign skip_status   = RUNNING_STATUS && rs_valid && is_channel &&
                         (event_command == rs_cmd) && !force_refresh;
  assign nbytes_in     = data_count(event_command);

  // While idle the byte for the next state comes straight from the offered event.
  assign cmd_src = (state == IDLE) ? event_command      : cmd_q;
  assign p1_src  = (state == IDLE) ? event_param_1[6:0] : p1_q;
  assign p2_src  = (state == IDLE) ? event_param_2[6:0] : p2_q;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (accept_ok) next_state = skip_status ? SEND_P1 : SEND_STATUS;
      SEND_STATUS: if (!tx_wait)  next_state = (nbytes_q != 2'd0) ? SEND_P1 : IDLE;
      SEND_P1:     if (!tx_wait)  next_state = (nbytes_q == 2'd2) ? SEND_P2 : IDLE;
      SEND_P2:     if (!tx_wait)  next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_comb begin
    tx_data_next = tx_data;
    case (next_state)
      SEND_STATUS: tx_data_next = cmd_src;
      SEND_P1:     tx_data_next = {1'b0, p1_src};
      SEND_P2:     tx_data_next = {1'b0, p2_src};
      default:     tx_data_next = tx_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_data       <= 8'h00;
      event_dropped <= 1'b0;
      cmd_q         <= 8'h00;
      p1_q          <= 7'h00;
      p2_q          <= 7'h00;
      nbytes_q      <= 2'd0;
      rs_valid      <= 1'b0;
      rs_cmd        <= 8'h00;
      rs_cnt        <= '0;
    end else begin
      tx_data       <= tx_data_next;
      event_dropped <= accept && !event_command[7];
      if (accept_ok) begin
        cmd_q    <= event_command;
        p1_q     <= event_param_1[6:0];
        p2_q     <= event_param_2[6:0];
        nbytes_q <= nbytes_in;
        // Realtime bytes leave running status untouched; system common cancels it.
        if (event_command[7:3] == 5'b11111) begin
          rs_valid <= rs_valid;
        end else if (event_command[7:4] == 4'hF) begin
          rs_valid <= 1'b0;
        end else if (skip_status) begin
          rs_cnt <= rs_cnt + 1'b1;
        end else begin
          rs_valid <= 1'b1;
          rs_cmd   <= event_command;
          rs_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_event_encoder.sv
// Self-checking bench for midi_event_encoder: a byte-queue model of the MIDI
// stream checked every cycle, plus literal expected streams per scenario.
module tb_midi_event_encoder;

  localparam int REFRESH = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       event_valid = 1'b0;
  logic       event_ready;
  logic [7:0] event_command = 8'h00;
  logic [7:0] event_param_1 = 8'h00;
  logic [7:0] event_param_2 = 8'h00;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_wait = 1'b0;
  logic       busy;
  logic       event_dropped;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] expQ[$];
  logic [7:0] seen[$];
  logic       dropPending = 1'b0;
  logic       mRsValid = 1'b0;
  logic [7:0] mRsCmd = 8'h00;
  int         mRsCnt = 0;
  logic       prevWe = 1'b0;
  logic       prevWait = 1'b0;
  logic [7:0] prevData = 8'h00;

  midi_event_encoder #(.RUNNING_STATUS(1'b1), .RS_REFRESH_EVENTS(REFRESH)) dut (
    .clk(clk), .resetn(resetn),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_command(event_command), .event_param_1(event_param_1),
    .event_param_2(event_param_2),
    .tx_data(tx_data), .tx_we(tx_we), .tx_wait(tx_wait),
    .busy(busy), .event_dropped(event_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nData(input logic [7:0] cmd);
    if (cmd == 8'hF2) return 2;
    if (cmd == 8'hF1 || cmd == 8'hF3) return 1;
    if (cmd >= 8'hF0) return 0;
    if (cmd >= 8'hC0 && cmd < 8'hE0) return 1;
    return 2;
  endfunction

  // Model of one accepted event: which bytes must appear on the wire.
  task automatic modelEvent(input logic [7:0] cmd, input logic [7:0] p1, input logic [7:0] p2);
    logic sendStatus;
    int n;
    if (!cmd[7]) begin
      dropPending = 1'b1;
      return;
    end
    n = nData(cmd);
    if (cmd >= 8'hF8) begin
      sendStatus = 1'b1;
    end else if (cmd >= 8'hF0) begin
      sendStatus = 1'b1;
      mRsValid = 1'b0;
    end else if (mRsValid && cmd == mRsCmd && mRsCnt != REFRESH - 1) begin
      sendStatus = 1'b0;
      mRsCnt++;
    end else begin
      sendStatus = 1'b1;
      mRsValid = 1'b1;
      mRsCmd = cmd;
      mRsCnt = 0;
    end
    if (sendStatus) expQ.push_back(cmd);
    if (n >= 1) expQ.push_back(p1 & 8'h7F);
    if (n == 2) expQ.push_back(p2 & 8'h7F);
  endtask

  task automatic waitIdle();
    int c = 0;
    while (expQ.size() != 0 && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 200) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL idle_timeout: %0d bytes still pending", expQ.size());
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] p1, input logic [7:0] p2);
    waitIdle();
    event_command = cmd;
    event_param_1 = p1;
    event_param_2 = p2;
    event_valid   = 1'b1;
    @(posedge clk);
    modelEvent(cmd, p1, p2);
    #1;
    event_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int n, input logic [127:0] exp);
    logic [7:0] e;
    check({name, "_len"}, 8'(seen.size()), 8'(n));
    for (int i = 0; i < n && i < seen.size(); i++) begin
      e = exp[8*(n-1-i) +: 8];
      check($sformatf("%s_byte%0d", name, i), seen[i], e);
    end
    seen.delete();
  endtask

  task automatic resetDut();
    #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    expQ.delete();
    seen.delete();
    mRsValid = 1'b0;
    mRsCnt = 0;
    dropPending = 1'b0;
    #1;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    check("reset_tx_data", tx_data, 8'h00);
  endtask

  // Per-cycle comparison of the handshake and byte stream against the model.
  always @(negedge clk) begin
    logic [7:0] b;
    if (!resetn) begin
      check("ready_in_reset", 8'(event_ready), 8'h00);
      prevWe = 1'b0;
    end else begin
      check("event_ready", 8'(event_ready), 8'(expQ.size() == 0));
      check("busy", 8'(busy), 8'(expQ.size() != 0));
      check("tx_we", 8'(tx_we), 8'(expQ.size() != 0));
      check("event_dropped", 8'(event_dropped), 8'(dropPending));
      dropPending = 1'b0;
      if (prevWe && prevWait) begin
        check("hold_we", 8'(tx_we), 8'h01);
        check("hold_data", tx_data, prevData);
      end
      if (tx_we && !tx_wait) begin
        seen.push_back(tx_data);
        if (expQ.size() != 0) begin
          b = expQ.pop_front();
          check("tx_byte", tx_data, b);
        end
      end
      prevWe = tx_we;
      prevWait = tx_wait;
      prevData = tx_data;
    end
  end

  initial begin
    resetDut();
    check("reset_we", 8'(tx_we), 8'h00);
    check("reset_busy", 8'(busy), 8'h00);
    check("reset_ready", 8'(event_ready), 8'h01);

    applyStimulus(8'h90, 8'h3C, 8'h64);
    check("first_we_latency", 8'(tx_we), 8'h01);
    applyStimulus(8'h90, 8'h3E, 8'h00);
    waitIdle();
    checkOutput("rs_basic", 5, {8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00});

    resetDut();
    applyStimulus(8'h90, 8'h3C, 8'h64);
    applyStimulus(8'hF8, 8'h00, 8'h00);
    applyStimulus(8'h90, 8'h40, 8'h7F);
    applyStimulus(8'hF2, 8'h12, 8'h34);
    applyStimulus(8'h90, 8'h40, 8'h00);
    waitIdle();
    checkOutput("realtime_syscommon", 12,
      {8'h90, 8'h3C, 8'h64, 8'hF8, 8'h40, 8'h7F, 8'hF2, 8'h12, 8'h34, 8'h90, 8'h40, 8'h00});

    resetDut();
    applyStimulus(8'hC5, 8'h87, 8'h55);
    applyStimulus(8'hD5, 8'h7F, 8'h66);
    waitIdle();
    checkOutput("one_param", 4, {8'hC5, 8'h07, 8'hD5, 8'h7F});

    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(8'hB0, 8'h07, 8'(i));
    waitIdle();
    checkOutput("refresh", 12,
      {8'hB0, 8'h07, 8'h00, 8'h07, 8'h01, 8'h07, 8'h02, 8'h07, 8'h03, 8'hB0, 8'h07, 8'h04});

    resetDut();
    applyStimulus(8'h90, 8'h11, 8'h22);
    @(posedge clk); #1;
    tx_wait = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    tx_wait = 1'b0;
    waitIdle();
    checkOutput("tx_wait_hold", 3, {8'h90, 8'h11, 8'h22});

    applyStimulus(8'hA0, 8'h33, 8'h44);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk);
    expQ.delete();
    seen.delete();
    mRsValid = 1'b0;
    mRsCnt = 0;
    #1;
    resetn = 1'b1;
    @(negedge clk); #1;
    check("midreset_we", 8'(tx_we), 8'h00);
    check("midreset_ready", 8'(event_ready), 8'h01);
    applyStimulus(8'h90, 8'h55, 8'h66);
    waitIdle();
    checkOutput("after_reset", 3, {8'h90, 8'h55, 8'h66});

    applyStimulus(8'h45, 8'h01, 8'h02);
    @(negedge clk); #1;
    check("dropped_ready", 8'(event_ready), 8'h01);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dropped", 0, 128'h0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/midi_event_encoder.md
Name: midi_event_encoder

Overview:
Converts framed MIDI events (command plus two parameters) into a serial MIDI byte stream for a simpleuart-style transmit port. It is the send-side counterpart of the MIDI framer. Typical uses are MIDI-thru/out, sequencer output, or loopback testing of the receive path. Supports running-status compression, realtime pass-through, and periodic status refresh.

Parameters:
RUNNING_STATUS, 1, 1 = omit a repeated channel status byte; 0 = always send the status byte.
RS_REFRESH_EVENTS, 16, force the status byte to be re-sent after this many consecutive running-status events; 0 = never force.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous reset, active low
event_valid  input  1  event offered
event_ready  output  1  encoder can accept an event this cycle
event_command  input  8  MIDI status byte
event_param_1  input  8  first data byte (bit 7 ignored)
event_param_2  input  8  second data byte (bit 7 ignored)
tx_data  output  8  byte to UART (reg_dat_di)
tx_we  output  1  write strobe to UART (reg_dat_we)
tx_wait  input  1  UART busy (reg_dat_wait)
busy  output  1  high in any state other than IDLE
event_dropped  output  1  one-cycle pulse when an invalid event is discarded

Behaviour:
- Reset: sampled on posedge clk while resetn=0, overriding everything else.
  - state=IDLE; tx_we=0; tx_data=0; event_dropped=0; busy=0.
  - Running-status register invalid; refresh counter=0.
  - Reset mid-transmission abandons the event. The partial byte is not completed.
- States: IDLE, SEND_STATUS, SEND_P1, SEND_P2.
- event_ready = (state==IDLE) && resetn. An event is accepted when event_valid && event_ready. Command and params are latched on that cycle.
- Data byte count by command:
  - 8x, 9x, Ax, Bx, Ex → 2.
  - Cx, Dx → 1.
  - F2 → 2; F1, F3 → 1.
  - F0, F4–F7 → 0.
  - F8–FF (realtime) → 0.
- Invalid command (bit 7 = 0): not latched for transmission. event_dropped pulses the following cycle. State stays IDLE and running status is unchanged.
- Status decision on acceptance:
  - Realtime (F8–FF): send status only; running status and refresh counter unchanged.
  - System common (F0–F7): send status; running status becomes invalid.
  - Channel (80–EF):
    - If RUNNING_STATUS=1, running status is valid, command equals it, and the refresh condition does not force a resend: skip the status byte and increment the refresh counter.
    - Otherwise send status, load the running-status register, and clear the counter.
    - Forced resend occurs when RS_REFRESH_EVENTS≠0 and counter == RS_REFRESH_EVENTS−1.
- Next state from IDLE on acceptance: SEND_STATUS, or SEND_P1 when status is skipped.
- Output handshake:
  - In each SEND state, tx_we=1 and tx_data holds the state's byte, registered, from the cycle after entry.
  - A byte is transferred on a cycle where tx_we=1 and tx_wait=0.
  - On transfer, advance to the next needed state (SEND_P1, SEND_P2, or IDLE); tx_we deasserts unless another byte follows.
  - While tx_wait=1, tx_we and tx_data hold stable indefinitely.
- Data bytes are sent as {1'b0, param[6:0]}.
- Latency: first tx_we rises 1 cycle after acceptance. With tx_wait=0 throughout, an N-byte event occupies N+1 cycles from acceptance to event_ready=1.
- Back-to-back: event_ready returns high in the cycle after the final byte transfers. No buffering beyond one event.
- event_valid while not ready is ignored; the source must hold the event until accepted.

Test Plan:
- RUNNING_STATUS=1, tx_wait=0: send {90,3C,64} then {90,3E,00} → bytes 90 3C 64 3E 00; first tx_we exactly 1 cycle after acceptance.
- Send {90,3C,64}, then {F8}, then {90,40,7F} → 90 3C 64 F8 40 7F; realtime does not cancel running status. Then {F2,12,34} followed by {90,40,00} → F2 12 34 90 40 00.
- Send {C5,87,xx}, then {D5,7F,xx} → C5 07 D5 7F; second param never sent; bit 7 masked.
- RS_REFRESH_EVENTS=4: five identical {B0,07,n} events → status B0 on events 1 and 5 only.
- Hold tx_wait=1 for 20 cycles mid-event → tx_we and tx_data stable; byte count and order unchanged. Pulse resetn low mid-event → tx_we=0 the next cycle, event_ready=1. The next {90,..} sends its status byte.
- Offer command 45 → event_dropped pulses once, no tx_we, event_ready stays 1.
